serdesphy_i2c_master: RTL and testbench
=======================================

Name: serdesphy_i2c_master

Overview:
I2C initiator that issues single-byte register writes and reads to the PHY's CSR responder over the sda/scl pins. It is used for on-chip configuration sequencing and as the bench-side companion that drives the CSR bus. It runs a command/response handshake on the user side and open-drain pin controls on the bus side. One clock; no CDC.

Parameters:
CLK_DIV, 60, clk_ref_24m cycles per quarter-bit tick (60 -> 100 kHz SCL); legal range 2..255
Q_W, 8, width of the quarter-bit divider counter

Ports:
clk_ref_24m  in  1  reference clock, sole clock domain
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_rw  in  1  0 = write, 1 = read
cmd_dev_addr  in  7  7-bit target address
cmd_reg_addr  in  8  CSR register address
cmd_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse at transaction end
rsp_rdata  out  8  read data, valid with rsp_valid; 0x00 for writes and NACK
rsp_nack  out  1  valid with rsp_valid; 1 = any ACK slot sampled high
busy  out  1  high from accept until the rsp_valid cycle inclusive
scl_oe  out  1  1 = pull SCL low; 0 = release
scl_in  in  1  sampled SCL pin level
sda_oe  out  1  1 = pull SDA low; 0 = release
sda_in  in  1  sampled SDA pin level

Behaviour:
- Reset (async): scl_oe=0, sda_oe=0, cmd_ready=1 after release, rsp_valid=0, rsp_rdata=0x00, rsp_nack=0, busy=0, state IDLE, divider cleared. A mid-transaction reset releases the bus immediately. No STOP is generated.
- Accept: all cmd_* fields are latched. cmd_ready drops the next cycle. cmd_valid while busy is ignored and the command is not queued.
- Tick: the divider counts 0..CLK_DIV-1 and pulses a tick on wrap. The divider is held at 0 in IDLE. One bit period = 4 ticks (phases P0..P3).
- Data bit phases:
  - P0: SCL low, drive SDA.
  - P1: release SCL.
  - P2: sample sda_in (SCL high).
  - P3: pull SCL low.
- Bit order is MSB first. The master releases SDA (sda_oe=0) during ACK slots and read-data bits.
- START (1 bit period): SDA released with SCL released, then SDA low, then SCL low.
- RSTART: same as START, preceded by SDA release while SCL is low.
- STOP (1 bit period): SDA low, SCL released, then SDA released.
- States: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, then either:
  - write: WDATA, ACK_D, STOP, DONE
  - read: RSTART, ADDR_R, ACK_A2, RDATA, MNACK, STOP, DONE
- Address bytes are {dev_addr, 0} and {dev_addr, 1}.
- MNACK: the master releases SDA (NACK) after the read byte.
- Any ACK slot sampling sda_in=1 moves to STOP next. In that case rsp_nack=1 and rsp_rdata=0x00.
- DONE: rsp_valid pulses for 1 cycle, then IDLE with cmd_ready=1 the following cycle. rsp_rdata and rsp_nack hold until the next rsp_valid.
- Duration (bit periods = 4*CLK_DIV cycles):
  - write: 29
  - read: 39
  - address NACK: 11
  - Tolerance: +2 clk cycles for accept/DONE overhead.
- No arbitration or bus-busy detection; single initiator.

Optional Feature:
SERDESPHY_I2C_STRETCH_EN
- Defined: in P1 the divider holds and the phase does not advance until scl_in==1, honouring responder clock stretching. No timeout.
- Undefined: scl_in is ignored and phases advance purely on ticks. The port remains present.

Test Plan:
- Write, CLK_DIV=4, dev 0x42, reg 0x05, data 0xA5, ACKing responder model -> SDA bytes 0x84, 0x05, 0xA5; rsp_valid with rsp_nack=0, rsp_rdata=0x00; 29 bit periods (464 +2 cycles).
- Read, dev 0x42, reg 0x05, responder returns 0x3C -> bytes 0x84, 0x05, RSTART, 0x85; master NACK on the 9th bit; STOP; rsp_rdata=0x3C, rsp_nack=0; 39 bit periods.
- No responder at 0x11 (SDA pulled high) -> STOP right after the address byte; rsp_nack=1, rsp_rdata=0x00; 11 bit periods.
- cmd_valid held during busy with a second command -> second command ignored until cmd_ready returns; exactly one rsp_valid per accepted command.
- rst asserted during the REG byte -> same cycle scl_oe=0, sda_oe=0; after release cmd_ready=1 and a new write completes normally.
- STRETCH_EN build: responder holds SCL low 50 cycles on one ACK -> the bit period extends by 50 cycles and the data is unchanged. Non-STRETCH build: timing unchanged.

Source files
------------

// File: rtl/serdesphy_i2c_master.sv
// Single-byte I2C register write/read initiator for the PHY CSR responder.
// Define SERDESPHY_I2C_STRETCH_EN to honour responder clock stretching on SCL.
module serdesphy_i2c_master #(
    parameter int CLK_DIV = 60,
    parameter int Q_W     = 8
) (
    input  logic       clk_ref_24m,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
        RSTART, ADDR_R, ACK_A2, RDATA, MNACK, STOP, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [Q_W-1:0] div_q, div_d;
    logic [1:0]     phase_q, phase_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     tx_q, tx_d, rx_q, rx_d;
    logic           samp_q, samp_d, nack_q, nack_d, rw_q, rw_d;
    logic [6:0]     dev_q, dev_d;
    logic [7:0]     reg_q, reg_d, wdata_q, wdata_d;
    logic [7:0]     rsp_rdata_q, rsp_rdata_d;
    logic           rsp_nack_q, rsp_nack_d;
    logic           active, stall, tick, bit_end, sample;

    assign active = (state_q != IDLE) && (state_q != DONE);

`ifdef SERDESPHY_I2C_STRETCH_EN
    // A responder holding SCL low freezes the high-phase until it lets go.
    assign stall = active && (phase_q == 2'd1) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif

    assign tick    = active && !stall && (div_q == Q_W'(CLK_DIV - 1));
    assign bit_end = tick && (phase_q == 2'd3);
    assign sample  = tick && (phase_q == 2'd2);

    always_ff @(posedge clk_ref_24m or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            phase_q     <= 2'd0;
            bit_cnt_q   <= 3'd0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            samp_q      <= 1'b0;
            nack_q      <= 1'b0;
            rw_q        <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            rsp_rdata_q <= 8'h00;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            samp_q      <= samp_d;
            nack_q      <= nack_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        samp_d      = samp_q;
        nack_d      = nack_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;

        if (!active) begin
            div_d   = '0;
            phase_d = 2'd0;
        end else if (tick) begin
            div_d   = '0;
            phase_d = phase_q + 2'd1;
        end else if (!stall) begin
            div_d = div_q + Q_W'(1);
        end

        if (sample) begin
            samp_d = sda_in;
            if (state_q == RDATA) rx_d = {rx_q[6:0], sda_in};
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    dev_d   = cmd_dev_addr;
                    reg_d   = cmd_reg_addr;
                    wdata_d = cmd_wdata;
                    rx_d    = 8'h00;
                    nack_d  = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                tx_d      = {dev_q, 1'b0};
                bit_cnt_d = 3'd0;
                state_d   = ADDR_W;
            end
            RSTART: if (bit_end) begin
                tx_d      = {dev_q, 1'b1};
                bit_cnt_d = 3'd0;
                state_d   = ADDR_R;
            end
            ADDR_W, REG, WDATA, ADDR_R, RDATA: if (bit_end) begin
                tx_d      = {tx_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    unique case (state_q)
                        ADDR_W:  state_d = ACK_A;
                        REG:     state_d = ACK_R;
                        WDATA:   state_d = ACK_D;
                        ADDR_R:  state_d = ACK_A2;
                        default: state_d = MNACK;
                    endcase
                end
            end
            // Any responder NACK abandons the transfer straight to STOP.
            ACK_A, ACK_R, ACK_D, ACK_A2: if (bit_end) begin
                bit_cnt_d = 3'd0;
                if (samp_q || state_q == ACK_D) begin
                    nack_d  = nack_q | samp_q;
                    state_d = STOP;
                end else if (state_q == ACK_A) begin
                    tx_d    = reg_q;
                    state_d = REG;
                end else if (state_q == ACK_R) begin
                    tx_d    = wdata_q;
                    state_d = rw_q ? RSTART : WDATA;
                end else begin
                    state_d = RDATA;
                end
            end
            MNACK: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                rsp_rdata_d = (nack_q || !rw_q) ? 8'h00 : rx_q;
                rsp_nack_d  = nack_q;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Open-drain pin controls: 1 pulls the line low, 0 releases it.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            START: begin
                sda_oe = phase_q[1];
                scl_oe = (phase_q == 2'd3);
            end
            RSTART: begin
                sda_oe = phase_q[1];
                scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
            end
            STOP: begin
                sda_oe = (phase_q != 2'd3);
                scl_oe = (phase_q == 2'd0);
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                sda_oe = !tx_q[7];
                scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
            end
            ACK_A, ACK_R, ACK_D, ACK_A2, RDATA, MNACK: begin
                scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;

endmodule

// File: tb/tb_serdesphy_i2c_master.sv
// Directed bench for serdesphy_i2c_master with a behavioural open-drain CSR responder.
// Covers writes, reads, address NACK, busy back-pressure, mid-transfer reset and stretching.
module tb_serdesphy_i2c_master;

    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = 4 * CLK_DIV;

    logic       clk_ref_24m = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev_addr = 7'h00;
    logic [7:0] cmd_reg_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe, scl_in, sda_oe, sda_in;

    logic slv_sda_low, slv_scl_low;
    logic scl_line, sda_line;
    assign scl_line = !(scl_oe || slv_scl_low);
    assign sda_line = !(sda_oe || slv_sda_low);
    assign scl_in   = scl_line;
    assign sda_in   = sda_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int rsp_count = 0;

    serdesphy_i2c_master #(.CLK_DIV(CLK_DIV), .Q_W(8)) dut (
        .clk_ref_24m (clk_ref_24m),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_dev_addr(cmd_dev_addr),
        .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_nack    (rsp_nack),
        .busy        (busy),
        .scl_oe      (scl_oe),
        .scl_in      (scl_in),
        .sda_oe      (sda_oe),
        .sda_in      (sda_in)
    );

    always #5 clk_ref_24m = !clk_ref_24m;

    always @(posedge clk_ref_24m) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready && !rst) acc_count <= acc_count + 1;
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    // Responder model: acks its own address, returns slv_rdata on reads.
    logic [6:0] slv_addr = 7'h42;
    logic [7:0] slv_rdata = 8'h00;
    logic       prev_scl, prev_sda;
    int         slv_cnt, slv_byte, hcnt;
    logic [7:0] slv_sh;
    logic       slv_addressed, slv_rd_pend, slv_tx, slv_hold, mack;
    logic       stretch_en = 1'b0;
    int         stretch_byte = 1;
    int         starts = 0;
    int         stops = 0;
    logic [7:0] cap_q[$];
    logic       slv_match;
    assign slv_match = (slv_sh[7:1] == slv_addr);

    always @(posedge clk_ref_24m or posedge rst) begin
        if (rst) begin
            prev_scl <= 1'b1; prev_sda <= 1'b1;
            slv_cnt <= 0; slv_byte <= 0; hcnt <= 0; slv_sh <= 8'h00;
            slv_addressed <= 1'b0; slv_rd_pend <= 1'b0; slv_tx <= 1'b0;
            slv_hold <= 1'b0; slv_scl_low <= 1'b0; slv_sda_low <= 1'b0; mack <= 1'b0;
        end else begin
            prev_scl <= scl_line;
            prev_sda <= sda_line;
            if (slv_hold && !scl_oe) begin
                if (hcnt == 49) begin
                    slv_hold <= 1'b0;
                    slv_scl_low <= 1'b0;
                end else begin
                    hcnt <= hcnt + 1;
                end
            end
            if (prev_scl && scl_line && prev_sda && !sda_line) begin
                starts <= starts + 1;
                slv_cnt <= 0; slv_byte <= 0; slv_tx <= 1'b0;
                slv_rd_pend <= 1'b0; slv_sda_low <= 1'b0;
            end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
                stops <= stops + 1;
                slv_cnt <= 0; slv_tx <= 1'b0; slv_sda_low <= 1'b0; slv_addressed <= 1'b0;
            end else if (!prev_scl && scl_line) begin
                if (slv_cnt < 8) begin
                    if (!slv_tx) slv_sh <= {slv_sh[6:0], sda_line};
                    slv_cnt <= slv_cnt + 1;
                end else begin
                    if (slv_tx) mack <= sda_line;
                    slv_cnt <= 9;
                end
            end else if (prev_scl && !scl_line) begin
                if (slv_cnt == 8) begin
                    if (slv_tx) begin
                        slv_sda_low <= 1'b0;
                    end else begin
                        cap_q.push_back(slv_sh);
                        if (slv_byte == 0) begin
                            slv_addressed <= slv_match;
                            slv_rd_pend <= slv_match && slv_sh[0];
                            slv_sda_low <= slv_match;
                        end else begin
                            slv_sda_low <= slv_addressed;
                        end
                        if (stretch_en && slv_byte == stretch_byte) begin
                            slv_hold <= 1'b1;
                            slv_scl_low <= 1'b1;
                            hcnt <= 0;
                        end
                    end
                end else if (slv_cnt == 9) begin
                    slv_cnt <= 0;
                    slv_byte <= slv_byte + 1;
                    slv_rd_pend <= 1'b0;
                    slv_tx <= slv_rd_pend;
                    slv_sda_low <= slv_rd_pend && !slv_rdata[7];
                end else if (slv_tx && slv_cnt > 0) begin
                    slv_sda_low <= !slv_rdata[7 - slv_cnt];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] packBytes();
        logic [31:0] p = 32'h0;
        foreach (cap_q[i]) p = {p[23:0], cap_q[i]};
        return p;
    endfunction

    // Duration is counted from the accepting edge to the edge that raises rsp_valid.
    task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                                 input logic [7:0] wd, output int dur);
        int t0;
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk_ref_24m); n++; end
        cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(negedge clk_ref_24m);
        t0 = cyc;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk_ref_24m); n++; end
        checkOutput("rsp_seen", rsp_valid, 1'b1);
        dur = cyc - t0;
    endtask

    function automatic int inWindow(input int dur, input int lo);
        return (dur >= lo && dur <= lo + 2) ? lo : dur;
    endfunction

    initial begin
        int dur, s0, p0, a0, r0, n;

        repeat (3) @(negedge clk_ref_24m);
        checkOutput("rst_scl_oe", scl_oe, 1'b0);
        checkOutput("rst_sda_oe", sda_oe, 1'b0);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 8'h00);
        checkOutput("rst_rsp_nack", rsp_nack, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk_ref_24m);
        checkOutput("rst_cmd_ready", cmd_ready, 1'b1);

        $display("[TB] write 0x42/0x05 <- 0xA5");
        cap_q.delete(); s0 = starts; p0 = stops;
        applyStimulus(1'b0, 7'h42, 8'h05, 8'hA5, dur);
        checkOutput("wr_nack", rsp_nack, 1'b0);
        checkOutput("wr_rdata", rsp_rdata, 8'h00);
        checkOutput("wr_dur", inWindow(dur, 29 * BIT_CYC), 29 * BIT_CYC);
        checkOutput("wr_nbytes", cap_q.size(), 3);
        checkOutput("wr_bytes", packBytes(), 32'h008405A5);
        checkOutput("wr_starts", starts - s0, 1);
        checkOutput("wr_stops", stops - p0, 1);
        @(negedge clk_ref_24m);
        checkOutput("wr_rsp_pulse", rsp_valid, 1'b0);
        checkOutput("wr_ready_back", cmd_ready, 1'b1);

        $display("[TB] read 0x42/0x05 -> 0x3C");
        cap_q.delete(); s0 = starts; p0 = stops; slv_rdata = 8'h3C;
        applyStimulus(1'b1, 7'h42, 8'h05, 8'hFF, dur);
        checkOutput("rd_nack", rsp_nack, 1'b0);
        checkOutput("rd_rdata", rsp_rdata, 8'h3C);
        checkOutput("rd_dur", inWindow(dur, 39 * BIT_CYC), 39 * BIT_CYC);
        checkOutput("rd_bytes", packBytes(), 32'h00840585);
        checkOutput("rd_starts", starts - s0, 2);
        checkOutput("rd_stops", stops - p0, 1);
        checkOutput("rd_master_nack", mack, 1'b1);
        repeat (3) @(negedge clk_ref_24m);
        checkOutput("rd_rdata_hold", rsp_rdata, 8'h3C);

        $display("[TB] absent responder at 0x11");
        cap_q.delete(); p0 = stops;
        applyStimulus(1'b0, 7'h11, 8'h05, 8'hA5, dur);
        checkOutput("an_nack", rsp_nack, 1'b1);
        checkOutput("an_rdata", rsp_rdata, 8'h00);
        checkOutput("an_dur", inWindow(dur, 11 * BIT_CYC), 11 * BIT_CYC);
        checkOutput("an_bytes", packBytes(), 32'h00000022);
        checkOutput("an_stops", stops - p0, 1);

        $display("[TB] cmd_valid held while busy");
        cap_q.delete();
        @(negedge clk_ref_24m);
        a0 = acc_count; r0 = rsp_count;
        cmd_rw = 1'b0; cmd_dev_addr = 7'h42; cmd_reg_addr = 8'h01; cmd_wdata = 8'h11;
        cmd_valid = 1'b1;
        @(negedge clk_ref_24m);
        cmd_reg_addr = 8'h02; cmd_wdata = 8'h22;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk_ref_24m); n++; end
        checkOutput("bb_first_rsp", rsp_valid, 1'b1);
        checkOutput("bb_accepts_busy", acc_count - a0, 1);
        @(negedge clk_ref_24m);
        @(negedge clk_ref_24m);
        cmd_valid = 1'b0;
        checkOutput("bb_second_busy", busy, 1'b1);
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk_ref_24m); n++; end
        checkOutput("bb_second_rsp", rsp_valid, 1'b1);
        repeat (20) @(negedge clk_ref_24m);
        checkOutput("bb_accepts", acc_count - a0, 2);
        checkOutput("bb_rsps", rsp_count - r0, 2);
        checkOutput("bb_nbytes", cap_q.size(), 6);
        checkOutput("bb_bytes", packBytes(), 32'h11840222);

        $display("[TB] reset during REG byte");
        cap_q.delete();
        cmd_rw = 1'b0; cmd_dev_addr = 7'h42; cmd_reg_addr = 8'h5A; cmd_wdata = 8'h3C;
        cmd_valid = 1'b1;
        @(negedge clk_ref_24m);
        cmd_valid = 1'b0;
        n = 0;
        while (cap_q.size() < 1 && n < 2000) begin @(negedge clk_ref_24m); n++; end
        checkOutput("mr_addr_seen", cap_q.size(), 1);
        repeat (2 * BIT_CYC + 4) @(negedge clk_ref_24m);
        rst = 1'b1;
        #1;
        checkOutput("mr_scl_oe", scl_oe, 1'b0);
        checkOutput("mr_sda_oe", sda_oe, 1'b0);
        checkOutput("mr_busy", busy, 1'b0);
        repeat (3) @(negedge clk_ref_24m);
        rst = 1'b0;
        @(negedge clk_ref_24m);
        checkOutput("mr_cmd_ready", cmd_ready, 1'b1);
        cap_q.delete();
        applyStimulus(1'b0, 7'h42, 8'h5A, 8'h3C, dur);
        checkOutput("mr_wr_nack", rsp_nack, 1'b0);
        checkOutput("mr_wr_dur", inWindow(dur, 29 * BIT_CYC), 29 * BIT_CYC);
        checkOutput("mr_wr_bytes", packBytes(), 32'h00845A3C);

`ifdef SERDESPHY_I2C_STRETCH_EN
        $display("[TB] responder stretches SCL on the REG ack");
        repeat (4) @(negedge clk_ref_24m);
        cap_q.delete();
        stretch_en = 1'b1; stretch_byte = 1;
        applyStimulus(1'b0, 7'h42, 8'h07, 8'h99, dur);
        stretch_en = 1'b0;
        checkOutput("st_nack", rsp_nack, 1'b0);
        checkOutput("st_dur", inWindow(dur, 29 * BIT_CYC + 50), 29 * BIT_CYC + 50);
        checkOutput("st_bytes", packBytes(), 32'h00840799);
`endif

        repeat (4) @(negedge clk_ref_24m);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
